// File: rtl/hps_cmd_sequencer.sv
// Command sequencer between HPS PIO ports: a toggle-handshaked command word drives
// a small accumulator, a pulse-train generator and a registered status word.
module hps_cmd_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd_in,
    output logic [31:0] status_out,
    output logic        pulse_out
);

    typedef enum logic [1:0] {IDLE, EXEC, COUNT, ACK} state_t;

    state_t             state, state_nx;
    logic               req_seen, req_seen_nx;
    logic               ack, ack_nx;
    logic               busy, busy_nx;
    logic               err, err_nx;
    logic               carry, carry_nx;
    logic               pulse_nx;
    logic [11:0]        cmd_cnt, cmd_cnt_nx;
    logic [15:0]        acc, acc_nx;
    logic [15:0]        arg_q, arg_nx;
    logic [2:0]         op_q, op_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [16:0]        sum;
    logic               unused_cmd_bits;

    assign unused_cmd_bits = ^cmd_in[27:16];
    assign sum = {1'b0, acc} + {1'b0, arg_q};

    // Every status field is a flop, so status_out has no combinational path from cmd_in.
    assign status_out = {ack, busy, err, carry, cmd_cnt, acc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_seen  <= 1'b0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            carry     <= 1'b0;
            pulse_out <= 1'b0;
            cmd_cnt   <= '0;
            acc       <= '0;
            arg_q     <= '0;
            op_q      <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            req_seen  <= req_seen_nx;
            ack       <= ack_nx;
            busy      <= busy_nx;
            err       <= err_nx;
            carry     <= carry_nx;
            pulse_out <= pulse_nx;
            cmd_cnt   <= cmd_cnt_nx;
            acc       <= acc_nx;
            arg_q     <= arg_nx;
            op_q      <= op_nx;
            cnt       <= cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        req_seen_nx = req_seen;
        ack_nx      = ack;
        busy_nx     = busy;
        err_nx      = err;
        carry_nx    = carry;
        pulse_nx    = pulse_out;
        cmd_cnt_nx  = cmd_cnt;
        acc_nx      = acc;
        arg_nx      = arg_q;
        op_nx       = op_q;
        cnt_nx      = cnt;

        case (state)
            IDLE: begin
                // cmd_in is only looked at here, so toggles while busy collapse into one.
                if (cmd_in[31] != req_seen) begin
                    op_nx       = cmd_in[30:28];
                    arg_nx      = cmd_in[15:0];
                    req_seen_nx = cmd_in[31];
                    busy_nx     = 1'b1;
                    state_nx    = EXEC;
                end
            end
            EXEC: begin
                state_nx = ACK;
                case (op_q)
                    3'd1: begin
                        acc_nx   = arg_q;
                        carry_nx = 1'b0;
                    end
                    3'd2: {carry_nx, acc_nx} = sum;
                    3'd3: begin
                        if (arg_q != 16'd0) begin
                            cnt_nx   = CNT_W'(arg_q);
                            pulse_nx = 1'b1;
                            state_nx = COUNT;
                        end
                    end
                    3'd4: begin
                        acc_nx   = '0;
                        carry_nx = 1'b0;
                        err_nx   = 1'b0;
                    end
                    3'd5, 3'd6, 3'd7: err_nx = 1'b1;
                    default: ;
                endcase
            end
            COUNT: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    pulse_nx = 1'b0;
                    state_nx = ACK;
                end
            end
            ACK: begin
                ack_nx     = req_seen;
                busy_nx    = 1'b0;
                cmd_cnt_nx = cmd_cnt + 12'd1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
